psd_sweep_ctrl: RTL and testbench



---
 rtl/psd_pkg.sv | 25 ++
 rtl/psd_edge_cnt.sv | 41 ++++
 rtl/psd_sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_psd_sweep_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psd_pkg
// Brief    : Shared types and default widths for the PSD sweep controller.
// Revision : 1.0 - initial release
// ============================================================================
package psd_pkg;

    localparam int FTW_W_DEF    = 32;
    localparam int NPTS_W_DEF   = 10;
    localparam int SETTLE_W_DEF = 16;
    localparam int RES_W        = 36;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_WAIT_AVG = 3'd3,
        ST_HOLD     = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/psd_edge_cnt.sv
`default_nettype none
// ============================================================================
// Module   : psd_edge_cnt
// Brief    : Rising-edge detector on the average flag with a discard counter;
//            hit fires on the first edge after DISCARD edges while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module psd_edge_cnt #(
    parameter int DISCARD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flag,
    input  logic en,
    output logic hit
);

    logic       flag_q;
    logic [1:0] cnt;
    logic       rise;

    assign rise = flag & ~flag_q;
    assign hit  = en & rise & (cnt == 2'd0);

    // Counter is parked at DISCARD whenever not enabled, so edges seen
    // before the wait window never consume a discard slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            cnt    <= 2'(DISCARD);
        end else begin
            flag_q <= flag;
            if (!en)
                cnt <= 2'(DISCARD);
            else if (rise && cnt != 2'd0)
                cnt <= cnt - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psd_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psd_sweep_ctrl
// Brief    : Frequency-sweep scheduler: steps the NCO tuning word, clears the
//            filters, waits for settling and hands one X/Y result per point.
// Revision : 1.0 - initial release
// ============================================================================
module psd_sweep_ctrl
    import psd_pkg::*;
#(
    parameter int FTW_W    = FTW_W_DEF,
    parameter int NPTS_W   = NPTS_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF,
    parameter int DISCARD  = 1,
    parameter int TMO_CYC  = 65535
) (
    input  logic                i_clk_1M,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [FTW_W-1:0]    i_f_start,
    input  logic [FTW_W-1:0]    i_f_step,
    input  logic [NPTS_W-1:0]   i_n_points,
    input  logic [SETTLE_W-1:0] i_settle_cycles,
    input  logic [3:0]          i_coe_cfg,
    input  logic [1:0]          i_mod_cfg,
    input  logic                i_aver_flag,
    input  logic [RES_W-1:0]    i_A_X,
    input  logic [RES_W-1:0]    i_A_Y,
    input  logic [RES_W-1:0]    i_B_X,
    input  logic [RES_W-1:0]    i_B_Y,
    output logic [FTW_W-1:0]    o_ftw,
    output logic                o_ftw_load,
    output logic                o_filt_clr,
    output logic [3:0]          o_coe,
    output logic [1:0]          o_mod,
    output logic [RES_W-1:0]    o_A_X,
    output logic [RES_W-1:0]    o_A_Y,
    output logic [RES_W-1:0]    o_B_X,
    output logic [RES_W-1:0]    o_B_Y,
    output logic [NPTS_W-1:0]   o_pt_idx,
    output logic                o_pt_valid,
    input  logic                i_rd_ack,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    // TMO_CYC is expected to be at least 1
    localparam int               TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t              state;
    logic [FTW_W-1:0]    f_step;
    logic [NPTS_W-1:0]   n_pts;
    logic [NPTS_W-1:0]   idx;
    logic [SETTLE_W-1:0] settle_cfg;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                avg_hit;

    psd_edge_cnt #(
        .DISCARD (DISCARD)
    ) u_edge_cnt (
        .clk   (i_clk_1M),
        .rst_n (i_rst_n),
        .flag  (i_aver_flag),
        .en    (state == ST_WAIT_AVG),
        .hit   (avg_hit)
    );

    // Strobes are pure decodes of the state register, so they are glitch-free
    assign o_ftw_load = (state == ST_LOAD);
    assign o_filt_clr = (state == ST_LOAD);
    assign o_done     = (state == ST_DONE);
    assign o_busy     = (state != ST_IDLE);

    always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            f_step     <= '0;
            n_pts      <= '0;
            idx        <= '0;
            settle_cfg <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            o_ftw      <= '0;
            o_coe      <= '0;
            o_mod      <= '0;
            o_A_X      <= '0;
            o_A_Y      <= '0;
            o_B_X      <= '0;
            o_B_Y      <= '0;
            o_pt_idx   <= '0;
            o_pt_valid <= 1'b0;
            o_err      <= 1'b0;
        end else if (i_abort && state != ST_IDLE) begin
            // Abort outranks ack and capture; tuning word and config are kept
            state      <= ST_IDLE;
            o_pt_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        f_step     <= i_f_step;
                        n_pts      <= i_n_points;
                        settle_cfg <= i_settle_cycles;
                        o_ftw      <= i_f_start;
                        o_coe      <= i_coe_cfg;
                        o_mod      <= i_mod_cfg;
                        idx        <= '0;
                        o_err      <= 1'b0;
                        state      <= (i_n_points == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == settle_cfg) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_AVG;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_WAIT_AVG: begin
                    if (avg_hit) begin
                        o_A_X      <= i_A_X;
                        o_A_Y      <= i_A_Y;
                        o_B_X      <= i_B_X;
                        o_B_Y      <= i_B_Y;
                        o_pt_idx   <= idx;
                        o_pt_valid <= 1'b1;
                        state      <= ST_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_err <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_rd_ack) begin
                        o_pt_valid <= 1'b0;
                        state      <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx == n_pts - NPTS_W'(1)) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        o_ftw <= o_ftw + f_step;
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psd_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_psd_sweep_ctrl
// Brief    : Directed self-checking bench for the PSD sweep controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psd_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, aver_flag, rd_ack;
    logic [31:0] f_start, f_step;
    logic [9:0]  n_points;
    logic [15:0] settle;
    logic [3:0]  coe_cfg;
    logic [1:0]  mod_cfg;
    logic [35:0] a_x, a_y, b_x, b_y;
    logic [31:0] ftw;
    logic        ftw_load, filt_clr;
    logic [3:0]  coe;
    logic [1:0]  mod_o;
    logic [35:0] oa_x, oa_y, ob_x, ob_y;
    logic [9:0]  pt_idx;
    logic        pt_valid, busy, done, err;

    always #5 clk = ~clk;

    psd_sweep_ctrl #(
        .FTW_W    (32),
        .NPTS_W   (10),
        .SETTLE_W (16),
        .DISCARD  (1),
        .TMO_CYC  (200)
    ) dut (
        .i_clk_1M        (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_abort         (abort),
        .i_f_start       (f_start),
        .i_f_step        (f_step),
        .i_n_points      (n_points),
        .i_settle_cycles (settle),
        .i_coe_cfg       (coe_cfg),
        .i_mod_cfg       (mod_cfg),
        .i_aver_flag     (aver_flag),
        .i_A_X           (a_x),
        .i_A_Y           (a_y),
        .i_B_X           (b_x),
        .i_B_Y           (b_y),
        .o_ftw           (ftw),
        .o_ftw_load      (ftw_load),
        .o_filt_clr      (filt_clr),
        .o_coe           (coe),
        .o_mod           (mod_o),
        .o_A_X           (oa_x),
        .o_A_Y           (oa_y),
        .o_B_X           (ob_x),
        .o_B_Y           (ob_y),
        .o_pt_idx        (pt_idx),
        .o_pt_valid      (pt_valid),
        .i_rd_ack        (rd_ack),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err)
    );

    int checks = 0;
    int errors = 0;

    // Observation log: tuning words at each load strobe, done pulses, captured indices
    logic [31:0] load_q[$];
    logic [9:0]  idx_q[$];
    int          n_done = 0;
    logic        pv_q = 1'b0;

    always @(posedge clk) begin
        if (ftw_load) load_q.push_back(ftw);
        if (done) n_done++;
        if (pt_valid && !pv_q) idx_q.push_back(pt_idx);
        pv_q <= pt_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input int p);
        a_x = 36'hA_0000_0000 + 36'(p);
        a_y = 36'hB_0000_0000 + 36'(p);
        b_x = 36'hC_0000_0000 + 36'(p);
        b_y = 36'hD_0000_0000 + 36'(p);
    endtask

    // Flag edge every 50 cycles until a result is held; optional start pulse at start_at
    task automatic capture(input string tag, input int p, input int start_at);
        logic got;
        got = 1'b0;
        set_res(p);
        for (int c = 0; c < 300 && !got; c++) begin
            aver_flag = (c % 50 == 49);
            start     = (c == start_at);
            tick();
            got = pt_valid;
        end
        aver_flag = 1'b0;
        start     = 1'b0;
        check({tag, "_valid"}, 64'(got), 64'd1);
        check({tag, "_idx"}, 64'(pt_idx), 64'(p));
        check({tag, "_ax"}, 64'(oa_x), 64'h0000_000A_0000_0000 + 64'(p));
        check({tag, "_by"}, 64'(ob_y), 64'h0000_000D_0000_0000 + 64'(p));
    endtask

    task automatic ack(input string tag);
        repeat (5) tick();
        check({tag, "_hold"}, 64'(pt_valid), 64'd1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check({tag, "_ackclr"}, 64'(pt_valid), 64'd0);
        tick();
    endtask

    initial begin
        int first;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; aver_flag = 1'b0; rd_ack = 1'b0;
        f_start = '0; f_step = '0; n_points = '0; settle = '0;
        coe_cfg = '0; mod_cfg = '0;
        set_res(0);
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(pt_valid), 64'd0);
        check("rst_ftw", 64'(ftw), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Three-point sweep; config changed after start must not matter
        f_start = 32'h1000; f_step = 32'h100; n_points = 10'd3; settle = 16'd10;
        coe_cfg = 4'h5; mod_cfg = 2'h2;
        start = 1'b1;
        tick();
        start = 1'b0;
        f_step = 32'hDEAD; n_points = 10'd1;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_coe", 64'(coe), 64'h5);
        check("t1_mod", 64'(mod_o), 64'h2);
        check("t1_clr", 64'(filt_clr), 64'd1);
        for (int p = 0; p < 3; p++) begin
            capture("t1", p, -1);
            ack("t1");
            if (p < 2) begin
                check("t1_load", 64'(ftw_load), 64'd1);
                check("t1_ftw", 64'(ftw), 64'h1000 + 64'((p + 1) * 32'h100));
            end else begin
                check("t1_done", 64'(done), 64'd1);
                check("t1_busy_done", 64'(busy), 64'd1);
            end
        end
        tick();
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_ndone", 64'(n_done), 64'd1);
        check("t1_nload", 64'(load_q.size()), 64'd3);
        if (load_q.size() == 3) begin
            check("t1_ftw0", 64'(load_q[0]), 64'h1000);
            check("t1_ftw1", 64'(load_q[1]), 64'h1100);
            check("t1_ftw2", 64'(load_q[2]), 64'h1200);
        end
        check("t1_nidx", 64'(idx_q.size()), 64'd3);
        if (idx_q.size() == 3) check("t1_idx2", 64'(idx_q[2]), 64'd2);

        // Zero-point sweep
        load_q.delete();
        n_points = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_busy", 64'(busy), 64'd1);
        check("t2_done", 64'(done), 64'd1);
        check("t2_load", 64'(ftw_load), 64'd0);
        tick();
        check("t2_busy_end", 64'(busy), 64'd0);
        check("t2_done_end", 64'(done), 64'd0);
        check("t2_nload", 64'(load_q.size()), 64'd0);
        check("t2_ndone", 64'(n_done), 64'd2);

        // Edges during settle are ignored; second edge after settle captures
        n_points = 10'd1; settle = 16'd100; f_start = 32'h2000;
        set_res(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        first = -1;
        for (int c = 0; c < 200; c++) begin
            aver_flag = (c == 20 || c == 60 || c == 130 || c == 170);
            tick();
            if (pt_valid && first < 0) first = c;
        end
        aver_flag = 1'b0;
        check("t3_capcyc", 64'(first), 64'd170);
        check("t3_ax", 64'(oa_x), 64'hA_0000_0007);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        tick();
        check("t3_done", 64'(done), 64'd1);
        tick();

        // Timeout with no flag edges
        settle = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        first = -1;
        for (int c = 0; c < 260; c++) begin
            tick();
            if (err && first < 0) first = c;
        end
        check("t4_errcyc", 64'(first), 64'd201);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_ndone", 64'(n_done), 64'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_errclr", 64'(err), 64'd0);
        check("t4_busy2", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort", 64'(busy), 64'd0);

        // Abort together with ack at point 1; start while busy ignored
        load_q.delete();
        f_start = 32'h3000; f_step = 32'h10; n_points = 10'd3; settle = 16'd5;
        coe_cfg = 4'h9;
        start = 1'b1;
        tick();
        start = 1'b0;
        capture("t5a", 0, -1);
        ack("t5a");
        f_start = 32'h9999;
        capture("t5b", 1, 3);
        check("t5_ftw_hold", 64'(ftw), 64'h3010);
        abort = 1'b1;
        rd_ack = 1'b1;
        tick();
        abort = 1'b0;
        rd_ack = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_valid", 64'(pt_valid), 64'd0);
        check("t5_ftw", 64'(ftw), 64'h3010);
        check("t5_coe", 64'(coe), 64'h9);
        repeat (4) tick();
        check("t5_nload", 64'(load_q.size()), 64'd2);
        check("t5_ndone", 64'(n_done), 64'd3);

        // Tuning word wraps modulo 2^32
        load_q.delete();
        f_start = 32'hFFFF_FF80; f_step = 32'h100; n_points = 10'd2; settle = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        capture("t6a", 0, -1);
        ack("t6a");
        check("t6_load", 64'(ftw_load), 64'd1);
        check("t6_wrap", 64'(ftw), 64'h0000_0080);
        capture("t6b", 1, -1);
        ack("t6b");
        check("t6_done", 64'(done), 64'd1);
        tick();

        // Asynchronous reset mid-sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_ftw", 64'(ftw), 64'd0);
        check("rst_async_coe", 64'(coe), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
